fx_kport: RTL and testbench
===========================

Name: fx_kport

Overview:
- K-port (keypad) serial transfer engine for one PC-FX controller port. Two instances sit beside the gate array's KPC register block.
- The register block decodes CPU writes into a trigger pulse, mode and direction bits. It reads back the received word, busy and end flags.
- This block drives the pad's latch, clock and data-out pins, shifts 32 bits in (and optionally out), and raises the end flag and interrupt request (INTKP) on completion.

Parameters:
- HALF_PER, 4: CE ticks per half bit period of KP_CLK (valid range 1..255).
- LATCH_LEN, 8: CE ticks KP_LATCH is held high before the first bit (valid range 1..255).
- NBITS, 32: bits per transfer (valid range 1..32).

Ports:
- CLK  in  1  system clock
- RESn  in  1  reset, asynchronous, active-low
- CE  in  1  clock enable; all state advances only when CE=1 (except the KP_DI synchronizer)
- TRG  in  1  start pulse from the register block (one CE tick)
- MODE  in  1  1 = latch phase before shifting; 0 = no latch phase
- DIR  in  1  1 = receive only; 0 = receive and transmit TX_DATA
- TX_DATA  in  32  transmit word, sampled at start
- END_CLR  in  1  clears END (CPU read of the data register)
- IRQ_EN  in  1  interrupt enable
- RX_DATA  out  32  last completed received word
- BUSY  out  1  transfer in progress
- END  out  1  transfer-complete flag (sticky)
- INT  out  1  END & IRQ_EN, combinational
- KP_LATCH  out  1  pad latch, idle 0
- KP_CLK  out  1  pad clock, idle 1
- KP_DO  out  1  pad data out, idle 1
- KP_DI  in  1  pad data in, asynchronous to CLK

Behaviour:
- Reset (async) values:
  - RX_DATA=0, BUSY=0, END=0, KP_LATCH=0, KP_CLK=1, KP_DO=1.
  - State=IDLE; all counters, shift registers and synchronizer flops cleared.
  - Reset mid-transfer aborts immediately: pins return to idle levels and RX_DATA is left at 0.
- KP_DI passes through a 2-flop synchronizer clocked every CLK. Sampling uses the synchronized value.
- States: IDLE, LATCH, CLK_LO, CLK_HI.
- IDLE:
  - TRG=1 on a CE tick captures TX_DATA into the tx shift register, clears the bit counter, and sets BUSY=1 on the next tick.
  - MODE=1 enters LATCH; MODE=0 enters CLK_LO.
- LATCH: KP_LATCH=1 for exactly LATCH_LEN CE ticks, then CLK_LO.
- CLK_LO:
  - KP_CLK=0 for HALF_PER ticks.
  - If DIR=0, KP_DO = tx[bit] on entry (LSB first) and holds through the bit. If DIR=1, KP_DO stays 1.
  - On the last CLK_LO tick, synchronized KP_DI is shifted into rx[bit] (LSB first); then enter CLK_HI.
- CLK_HI:
  - KP_CLK=1 for HALF_PER ticks.
  - If more bits remain, bit increments and the state returns to CLK_LO.
  - After bit NBITS-1, on the final tick: RX_DATA <= rx shift register (unused upper bits zero), END=1, BUSY=0, KP_DO=1, state=IDLE.
- Timing with defaults and MODE=1: BUSY is high for 8 + 32*8 = 264 CE ticks; END rises the tick BUSY falls. With MODE=0: 256 ticks.
- RX_DATA is stable during a transfer and updates only at completion.
- TRG while BUSY=1 is ignored.
- END_CLR clears END on that CE tick.
- END_CLR on the same tick as completion: END is set (set wins).
- TRG with END_CLR in IDLE: both take effect.
- MODE, DIR and IRQ_EN changes mid-transfer: MODE is sampled only at start; DIR is sampled only at start; IRQ_EN acts live.
- CE=0 freezes state, counters and outputs.

Test Plan:
- Reset, then TRG with MODE=1, DIR=1; pad model drives 0xA5A5_0F0F LSB-first, updating KP_DI on KP_CLK falling edges -> KP_LATCH high 8 ticks, 32 KP_CLK pulses, RX_DATA=0xA5A5_0F0F, END=1 exactly 264 ticks after BUSY rise, KP_DO stays 1.
- DIR=0, TX_DATA=0x0000_0003, MODE=0 -> no latch pulse; KP_DO=1,1 then 0 for bits 2..31, sampled at KP_CLK rise; BUSY high 256 ticks.
- Second TRG at tick 100 of a busy transfer -> ignored; single transfer; RX_DATA unchanged until completion.
- IRQ_EN=1: END_CLR asserted the same tick as completion -> END=1, INT=1; END_CLR one tick later -> END=0, INT=0.
- RESn low at bit 10 -> KP_CLK=1, KP_LATCH=0, BUSY=0, RX_DATA=0 asynchronously; after release, a new TRG completes normally.
- CE toggled 1-of-3 cycles during a transfer -> identical pin sequence, stretched 3x; RX_DATA correct.

Source files
------------

// File: rtl/fx_kport.sv
// PC-FX K-port serial transfer engine: drives the pad latch, clock and data-out pins,
// and shifts NBITS bits in (and optionally out) LSB first, flagging completion on END/INT.
module fx_kport #(
  parameter int HALF_PER  = 4,
  parameter int LATCH_LEN = 8,
  parameter int NBITS     = 32
) (
  input  logic        CLK,
  input  logic        RESn,
  input  logic        CE,
  input  logic        TRG,
  input  logic        MODE,
  input  logic        DIR,
  input  logic [31:0] TX_DATA,
  input  logic        END_CLR,
  input  logic        IRQ_EN,
  output logic [31:0] RX_DATA,
  output logic        BUSY,
  output logic        END,
  output logic        INT,
  output logic        KP_LATCH,
  output logic        KP_CLK,
  output logic        KP_DO,
  input  logic        KP_DI
);

  typedef enum logic [1:0] {IDLE, LATCH, CLK_LO, CLK_HI} state_t;

  localparam logic [7:0] HALF_LAST  = 8'(HALF_PER - 1);
  localparam logic [7:0] LATCH_LAST = 8'(LATCH_LEN - 1);
  localparam logic [4:0] BIT_LAST   = 5'(NBITS - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [4:0]  bit_q;
  logic [4:0]  bit_d;
  logic [31:0] tx_q;
  logic [31:0] rx_q;
  logic [31:0] rx_out_q;
  logic        dir_q;
  logic        busy_q;
  logic        end_q;
  logic        latch_q;
  logic        kclk_q;
  logic        kdo_q;
  logic        di_s1_q;
  logic        di_s2_q;

  assign bit_d = bit_q + 5'd1;

  // KP_DI is asynchronous to CLK, so it is synchronized on every CLK regardless of CE.
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      di_s1_q <= 1'b0;
      di_s2_q <= 1'b0;
    end else begin
      di_s1_q <= KP_DI;
      di_s2_q <= di_s1_q;
    end
  end

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      bit_q    <= 5'd0;
      tx_q     <= 32'd0;
      rx_q     <= 32'd0;
      rx_out_q <= 32'd0;
      dir_q    <= 1'b0;
      busy_q   <= 1'b0;
      end_q    <= 1'b0;
      latch_q  <= 1'b0;
      kclk_q   <= 1'b1;
      kdo_q    <= 1'b1;
    end else if (CE) begin
      // A completion later in this block overrides the clear.
      if (END_CLR) end_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (TRG) begin
            tx_q   <= TX_DATA;
            rx_q   <= 32'd0;
            bit_q  <= 5'd0;
            cnt_q  <= 8'd0;
            dir_q  <= DIR;
            busy_q <= 1'b1;
            if (MODE) begin
              state_q <= LATCH;
              latch_q <= 1'b1;
            end else begin
              state_q <= CLK_LO;
              kclk_q  <= 1'b0;
              kdo_q   <= DIR | TX_DATA[0];
            end
          end
        end
        LATCH: begin
          if (cnt_q == LATCH_LAST) begin
            cnt_q   <= 8'd0;
            latch_q <= 1'b0;
            state_q <= CLK_LO;
            kclk_q  <= 1'b0;
            kdo_q   <= dir_q | tx_q[0];
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        CLK_LO: begin
          if (cnt_q == HALF_LAST) begin
            rx_q[bit_q] <= di_s2_q;
            cnt_q       <= 8'd0;
            kclk_q      <= 1'b1;
            state_q     <= CLK_HI;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        CLK_HI: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= 8'd0;
            if (bit_q == BIT_LAST) begin
              rx_out_q <= rx_q;
              end_q    <= 1'b1;
              busy_q   <= 1'b0;
              kdo_q    <= 1'b1;
              state_q  <= IDLE;
            end else begin
              bit_q   <= bit_d;
              kclk_q  <= 1'b0;
              kdo_q   <= dir_q | tx_q[bit_d];
              state_q <= CLK_LO;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign RX_DATA  = rx_out_q;
  assign BUSY     = busy_q;
  assign END      = end_q;
  assign INT      = end_q & IRQ_EN;
  assign KP_LATCH = latch_q;
  assign KP_CLK   = kclk_q;
  assign KP_DO    = kdo_q;

endmodule

// File: tb/tb_fx_kport.sv
// Directed bench for fx_kport: table of whole transfers plus hand sequences for
// completion/END_CLR overlap, IRQ_EN gating and asynchronous reset mid-transfer.
module tb_fx_kport;

  logic        CLK = 1'b0;
  logic        RESn = 1'b0;
  logic        CE = 1'b1;
  logic        TRG = 1'b0;
  logic        MODE = 1'b0;
  logic        DIR = 1'b0;
  logic [31:0] TX_DATA = 32'd0;
  logic        END_CLR = 1'b0;
  logic        IRQ_EN = 1'b0;
  logic [31:0] RX_DATA;
  logic        BUSY, END, INT, KP_LATCH, KP_CLK, KP_DO;
  logic        KP_DI = 1'b0;

  fx_kport #(.HALF_PER(4), .LATCH_LEN(8), .NBITS(32)) dut (
    .CLK(CLK), .RESn(RESn), .CE(CE), .TRG(TRG), .MODE(MODE), .DIR(DIR),
    .TX_DATA(TX_DATA), .END_CLR(END_CLR), .IRQ_EN(IRQ_EN), .RX_DATA(RX_DATA),
    .BUSY(BUSY), .END(END), .INT(INT), .KP_LATCH(KP_LATCH), .KP_CLK(KP_CLK),
    .KP_DO(KP_DO), .KP_DI(KP_DI)
  );

  int ce_div = 1;
  int ce_cnt = 0;
  int n_cmp  = 0;
  int n_fail = 0;

  // Clock period 10; CE for the next edge is updated 2 time units after each posedge.
  initial begin
    forever begin
      #5 CLK = 1'b1;
      #2 ce_cnt = (ce_cnt + 1) % ce_div;
      CE = (ce_cnt == 0);
      #3 CLK = 1'b0;
    end
  end

  // Pad model: presents the next pattern bit on each KP_CLK falling edge.
  logic [31:0] pat_q = 32'd0;
  int          pad_idx = 0;
  always @(negedge KP_CLK) begin
    if (pad_idx < 32) KP_DI = pat_q[pad_idx];
    pad_idx = pad_idx + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ce(input int n);
    int c = 0;
    logic ce_at;
    while (c < n) begin
      @(posedge CLK);
      ce_at = CE;
      #1;
      if (ce_at) c++;
    end
  endtask

  // Issues TRG (with END_CLR) on a CE tick; returns 1 time unit after that edge.
  task automatic start_trg(input logic mode, input logic dir, input logic [31:0] tx,
                           input logic [31:0] pat);
    MODE = mode; DIR = dir; TX_DATA = tx;
    pat_q = pat; pad_idx = 0;
    forever begin
      @(posedge CLK);
      #3;
      if (CE) break;
    end
    TRG = 1'b1; END_CLR = 1'b1;
    @(posedge CLK);
    #1;
    TRG = 1'b0; END_CLR = 1'b0;
  endtask

  typedef struct {
    logic        mode;
    logic        dir;
    logic [31:0] tx;
    logic [31:0] pat;
    int          cediv;
    int          retrig;
    int          exp_busy;
    int          exp_latch;
    logic [31:0] exp_do;
    logic [31:0] exp_rx;
  } vec_t;

  task automatic run_xfer(input vec_t v);
    logic [31:0] rx_before, do_word;
    logic        prev_latch, prev_clk, ce_at, rx_stable, done;
    int          ticks, lticks, rises, cyc;
    ce_div = v.cediv;
    rx_before = RX_DATA;
    start_trg(v.mode, v.dir, v.tx, v.pat);
    chk("busy_after_trg", {31'd0, BUSY}, 32'd1);
    chk("end_cleared_by_trg", {31'd0, END}, 32'd0);
    prev_latch = KP_LATCH; prev_clk = KP_CLK;
    ticks = 0; lticks = 0; rises = 0; cyc = 0;
    do_word = 32'd0; rx_stable = 1'b1; done = 1'b0;
    while (!done && cyc < 2000) begin
      @(posedge CLK);
      ce_at = CE;
      #1;
      cyc++;
      if (ce_at) begin
        ticks++;
        if (prev_latch) lticks++;
      end
      if (KP_CLK && !prev_clk) begin
        if (rises < 32) do_word[rises] = KP_DO;
        rises++;
      end
      if (BUSY && RX_DATA !== rx_before) rx_stable = 1'b0;
      if (ticks == v.retrig) begin
        TRG = 1'b1; MODE = ~v.mode; DIR = ~v.dir;
      end else begin
        TRG = 1'b0;
      end
      prev_latch = KP_LATCH; prev_clk = KP_CLK;
      if (!BUSY) done = 1'b1;
    end
    TRG = 1'b0; MODE = v.mode; DIR = v.dir;
    chk("no_timeout", {31'd0, done}, 32'd1);
    chk("busy_ticks", ticks, v.exp_busy);
    chk("latch_ticks", lticks, v.exp_latch);
    chk("clk_pulses", rises, 32);
    chk("kp_do_bits", do_word, v.exp_do);
    chk("rx_stable", {31'd0, rx_stable}, 32'd1);
    chk("rx_data", RX_DATA, v.exp_rx);
    chk("end_at_done", {31'd0, END}, 32'd1);
    chk("kp_do_idle", {31'd0, KP_DO}, 32'd1);
    repeat (20) @(posedge CLK);
    #1;
    chk("single_xfer", {31'd0, BUSY}, 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b1, 1'b1, 32'h0000_0000, 32'hA5A5_0F0F, 1, -1, 264, 8, 32'hFFFF_FFFF, 32'hA5A5_0F0F};
    vecs[1] = '{1'b0, 1'b0, 32'h0000_0003, 32'h1234_5678, 1, -1, 256, 0, 32'h0000_0003, 32'h1234_5678};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0000, 32'h3C96_5AC3, 3, -1, 264, 8, 32'hFFFF_FFFF, 32'h3C96_5AC3};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0000, 32'hCAFE_F00D, 1, 100, 264, 8, 32'hFFFF_FFFF, 32'hCAFE_F00D};
    vecs[4] = '{1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_FFFF, 3, -1, 256, 0, 32'hDEAD_BEEF, 32'h0000_FFFF};
    vecs[5] = '{1'b0, 1'b1, 32'h5555_AAAA, 32'h8000_0001, 1, 40, 256, 0, 32'hFFFF_FFFF, 32'h8000_0001};

    RESn = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_rx", RX_DATA, 32'd0);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_end", {31'd0, END}, 32'd0);
    chk("rst_latch", {31'd0, KP_LATCH}, 32'd0);
    chk("rst_clk", {31'd0, KP_CLK}, 32'd1);
    chk("rst_do", {31'd0, KP_DO}, 32'd1);
    RESn = 1'b1;
    repeat (2) @(posedge CLK);

    for (int i = 0; i < 6; i++) run_xfer(vecs[i]);

    // Completion and END_CLR on the same tick: set wins; IRQ_EN gates INT live.
    ce_div = 1;
    IRQ_EN = 1'b1;
    start_trg(1'b0, 1'b1, 32'd0, 32'h0F0F_F0F0);
    wait_ce(255);
    chk("busy_before_last", {31'd0, BUSY}, 32'd1);
    END_CLR = 1'b1;
    wait_ce(1);
    chk("busy_done_clr", {31'd0, BUSY}, 32'd0);
    chk("end_set_wins", {31'd0, END}, 32'd1);
    chk("int_set_wins", {31'd0, INT}, 32'd1);
    chk("rx_done_clr", RX_DATA, 32'h0F0F_F0F0);
    IRQ_EN = 1'b0;
    #1;
    chk("int_masked", {31'd0, INT}, 32'd0);
    IRQ_EN = 1'b1;
    #1;
    chk("int_unmasked", {31'd0, INT}, 32'd1);
    wait_ce(1);
    chk("end_cleared", {31'd0, END}, 32'd0);
    chk("int_cleared", {31'd0, INT}, 32'd0);
    END_CLR = 1'b0;

    // Asynchronous reset during bit 10 aborts the transfer and clears RX_DATA.
    start_trg(1'b1, 1'b1, 32'd0, 32'h1357_9BDF);
    wait_ce(8 + 10 * 8 + 2);
    chk("busy_mid", {31'd0, BUSY}, 32'd1);
    chk("clk_low_mid", {31'd0, KP_CLK}, 32'd0);
    #2 RESn = 1'b0;
    #1;
    chk("abort_clk", {31'd0, KP_CLK}, 32'd1);
    chk("abort_latch", {31'd0, KP_LATCH}, 32'd0);
    chk("abort_busy", {31'd0, BUSY}, 32'd0);
    chk("abort_rx", RX_DATA, 32'd0);
    chk("abort_do", {31'd0, KP_DO}, 32'd1);
    @(posedge CLK);
    #1 RESn = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rx_after_rst", RX_DATA, 32'd0);
    run_xfer(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
